// File: rtl/vec_mac_engine.sv
// Serial-load vector multiply/add engine: f = sum_i sat_or_wrap(a_i*b_i + d_i).
// Latency: out_valid rises LANES edges after the edge that accepts d[LANES-1].
// Backpressure: in_ready only while loading; result held in DONE until out_ready.
module vec_mac_engine #(
  parameter int WIDTH = 8,
  parameter int LANES = 4,
  parameter int CW    = $clog2(LANES)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             abort,
  input  logic             mode,
  input  logic [WIDTH-1:0] next_in,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] f,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy
);

  typedef enum logic [2:0] {IDLE, LOAD_A, LOAD_B, LOAD_D, COMPUTE, DONE} state_t;

  localparam logic [CW-1:0]    LAST = CW'(LANES - 1);
  localparam logic [WIDTH-1:0] MAXV = '1;

  state_t           state, state_nxt;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] acc;
  logic             mode_q;
  logic [WIDTH-1:0] a_q [LANES];
  logic [WIDTH-1:0] b_q [LANES];
  logic [WIDTH-1:0] d_q [LANES];

  logic             accept, last;
  logic [2*WIDTH-1:0] prod_full;
  logic [WIDTH-1:0]   prod, term, acc_nxt;
  logic [WIDTH:0]     term_full, acc_full;

  // in_ready is forced low while reset is held so nothing upstream sees a ready IDLE
  assign in_ready = reset && (state inside {IDLE, LOAD_A, LOAD_B, LOAD_D});
  assign accept   = in_valid && in_ready && !abort;
  assign last     = (cnt == LAST);
  assign busy     = (state != IDLE);

  // One lane of arithmetic; each stage clamps independently in saturate mode
  always_comb begin
    prod_full = {{WIDTH{1'b0}}, a_q[cnt]} * {{WIDTH{1'b0}}, b_q[cnt]};
    prod      = (mode_q && |prod_full[2*WIDTH-1:WIDTH]) ? MAXV : prod_full[WIDTH-1:0];
    term_full = {1'b0, prod} + {1'b0, d_q[cnt]};
    term      = (mode_q && term_full[WIDTH]) ? MAXV : term_full[WIDTH-1:0];
    acc_full  = {1'b0, acc} + {1'b0, term};
    acc_nxt   = (mode_q && acc_full[WIDTH]) ? MAXV : acc_full[WIDTH-1:0];
  end

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic; abort overrides every transition
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept)         state_nxt = LOAD_A;
      LOAD_A:  if (accept && last) state_nxt = LOAD_B;
      LOAD_B:  if (accept && last) state_nxt = LOAD_D;
      LOAD_D:  if (accept && last) state_nxt = COMPUTE;
      COMPUTE: if (last)           state_nxt = DONE;
      DONE:    if (out_ready)      state_nxt = IDLE;
      default:                     state_nxt = IDLE;
    endcase
    if (abort) state_nxt = IDLE;
  end

  // Datapath: vector capture, lane counter, accumulator and result register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt       <= '0;
      acc       <= '0;
      f         <= '0;
      out_valid <= 1'b0;
      mode_q    <= 1'b0;
      for (int i = 0; i < LANES; i++) begin
        a_q[i] <= '0;
        b_q[i] <= '0;
        d_q[i] <= '0;
      end
    end else if (abort) begin
      cnt       <= '0;
      acc       <= '0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          a_q[0] <= next_in;
          mode_q <= mode;
          cnt    <= CW'(1);
        end
        LOAD_A: if (accept) begin
          a_q[cnt] <= next_in;
          cnt      <= last ? '0 : cnt + CW'(1);
        end
        LOAD_B: if (accept) begin
          b_q[cnt] <= next_in;
          cnt      <= last ? '0 : cnt + CW'(1);
        end
        LOAD_D: if (accept) begin
          d_q[cnt] <= next_in;
          cnt      <= last ? '0 : cnt + CW'(1);
          if (last) acc <= '0;
        end
        COMPUTE: begin
          acc <= acc_nxt;
          cnt <= last ? '0 : cnt + CW'(1);
          if (last) begin
            f         <= acc_nxt;
            out_valid <= 1'b1;
          end
        end
        DONE: if (out_ready) out_valid <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_vec_mac_engine.sv
module tb_vec_mac_engine;
  localparam int WIDTH = 8;
  localparam int LANES = 4;
  localparam int MAXI  = (1 << WIDTH) - 1;

  logic             clk = 1'b0;
  logic             reset, abort, mode, in_valid, out_ready;
  logic [WIDTH-1:0] next_in;
  logic             in_ready, out_valid, busy;
  logic [WIDTH-1:0] f;

  int total = 0;
  int bad   = 0;

  logic [WIDTH-1:0] va [LANES];
  logic [WIDTH-1:0] vb [LANES];
  logic [WIDTH-1:0] vd [LANES];

  vec_mac_engine #(.WIDTH(WIDTH), .LANES(LANES)) dut (
    .clk(clk), .reset(reset), .abort(abort), .mode(mode),
    .next_in(next_in), .in_valid(in_valid), .in_ready(in_ready),
    .f(f), .out_valid(out_valid), .out_ready(out_ready), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Reference: plain integer arithmetic, clamping or wrapping each stage
  function automatic int fix(input int v, input int m);
    if (m != 0) return (v > MAXI) ? MAXI : v;
    return v % (MAXI + 1);
  endfunction

  function automatic int ref_f(input int m);
    int acc = 0;
    for (int i = 0; i < LANES; i++) begin
      int p, t;
      p   = fix(int'(va[i]) * int'(vb[i]), m);
      t   = fix(p + int'(vd[i]), m);
      acc = fix(acc + t, m);
    end
    return acc;
  endfunction

  task automatic send_beat(input logic [WIDTH-1:0] dat, input logic m, input int gap);
    @(negedge clk);
    for (int g = 0; g < gap; g++) begin
      in_valid = 1'b0;
      check("gap_in_ready", in_ready, 1);
      @(negedge clk);
    end
    in_valid = 1'b1;
    next_in  = dat;
    mode     = m;
    check("beat_in_ready", in_ready, 1);
    @(posedge clk);
  endtask

  task automatic run_vec(input logic m0, input logic mrest, input int gmin, input int gmax);
    for (int i = 0; i < 3 * LANES; i++) begin
      logic [WIDTH-1:0] dat;
      if (i < LANES)          dat = va[i];
      else if (i < 2 * LANES) dat = vb[i - LANES];
      else                    dat = vd[i - 2 * LANES];
      send_beat(dat, (i == 0) ? m0 : mrest, int'($urandom_range(gmax, gmin)));
    end
  endtask

  // Called right after the edge that accepted d[LANES-1]
  task automatic wait_result(input string tag, input int exp, input int hold);
    int lat = 0;
    @(negedge clk);
    in_valid = 1'b0;
    while (!out_valid && lat < 200) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    check({tag, "_latency"}, lat, LANES);
    check({tag, "_f"}, f, exp);
    in_valid = 1'b1;
    next_in  = WIDTH'($urandom);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check({tag, "_hold_vld"}, out_valid, 1);
      check({tag, "_hold_f"}, f, exp);
      check({tag, "_hold_rdy"}, in_ready, 0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    in_valid  = 1'b0;
    check({tag, "_drop_vld"}, out_valid, 0);
    check({tag, "_idle"}, busy, 0);
    check({tag, "_f_kept"}, f, exp);
    check({tag, "_idle_rdy"}, in_ready, 1);
  endtask

  initial begin
    bit seen;
    reset = 1'b0; abort = 1'b0; mode = 1'b0; in_valid = 1'b0;
    out_ready = 1'b0; next_in = '0;
    repeat (2) @(negedge clk);
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_f", f, 0);
    reset = 1'b1;

    // Wrap mode: each lane FE+03 wraps to 01
    for (int i = 0; i < LANES; i++) begin va[i] = 8'hFF; vb[i] = 8'h02; vd[i] = 8'h03; end
    run_vec(1'b0, 1'b0, 0, 0);
    wait_result("t1", 32'h04, 0);

    // Saturate mode on same vectors
    run_vec(1'b1, 1'b1, 0, 0);
    wait_result("t2", 32'hFF, 0);

    // Gapped input, in_ready must stay high through gaps
    for (int i = 0; i < LANES; i++) begin
      va[i] = WIDTH'(i + 1); vb[i] = WIDTH'(i + 5); vd[i] = '0;
    end
    run_vec(1'b0, 1'b0, 3, 3);
    wait_result("t3", 32'h46, 0);

    // Back-pressure with beats offered during DONE
    for (int i = 0; i < LANES; i++) begin
      va[i] = WIDTH'($urandom); vb[i] = WIDTH'($urandom); vd[i] = WIDTH'($urandom);
    end
    run_vec(1'b0, 1'b0, 0, 1);
    wait_result("t4", ref_f(0), 5);
    for (int i = 0; i < LANES; i++) begin
      va[i] = WIDTH'($urandom); vb[i] = WIDTH'($urandom); vd[i] = WIDTH'($urandom);
    end
    run_vec(1'b1, 1'b1, 0, 0);
    wait_result("t4_next", ref_f(1), 0);

    // Async reset mid LOAD_B
    for (int i = 0; i < LANES; i++) send_beat(8'hAA, 1'b1, 0);
    send_beat(8'hBB, 1'b1, 0);
    send_beat(8'hBB, 1'b1, 0);
    @(negedge clk);
    in_valid = 1'b0;
    #2 reset = 1'b0;
    #1;
    check("t5_rst_rdy", in_ready, 0);
    check("t5_rst_vld", out_valid, 0);
    check("t5_rst_busy", busy, 0);
    check("t5_rst_f", f, 0);
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < LANES; i++) begin
      va[i] = WIDTH'($urandom); vb[i] = WIDTH'($urandom); vd[i] = WIDTH'($urandom);
    end
    run_vec(1'b0, 1'b0, 0, 0);
    wait_result("t5", ref_f(0), 0);

    // Abort during COMPUTE lane 2
    run_vec(1'b0, 1'b0, 0, 0);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("t6_abort_busy", busy, 0);
    check("t6_abort_vld", out_valid, 0);
    seen = 1'b0;
    for (int c = 0; c < LANES + 3; c++) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    check("t6_no_output", seen, 0);

    // Mode sampled on a[0] only
    for (int i = 0; i < LANES; i++) begin
      va[i] = WIDTH'($urandom_range(255, 128));
      vb[i] = WIDTH'($urandom_range(255, 128));
      vd[i] = WIDTH'($urandom_range(255, 128));
    end
    run_vec(1'b1, 1'b0, 0, 0);
    wait_result("t6_mode", ref_f(1), 0);

    // Randomized vectors, modes, gaps and back-pressure
    for (int n = 0; n < 12; n++) begin
      logic m;
      m = 1'($urandom);
      for (int i = 0; i < LANES; i++) begin
        va[i] = WIDTH'($urandom); vb[i] = WIDTH'($urandom); vd[i] = WIDTH'($urandom);
      end
      run_vec(m, 1'($urandom), 0, 2);
      wait_result("rnd", ref_f(int'(m)), int'($urandom_range(3, 0)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
